// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// FSM state encoding, vector count and index/counter widths.
package tt_pkg;

    localparam int unsigned TT_VECTORS = 16;
    localparam int unsigned TT_IDX_W   = 4;
    localparam int unsigned TT_CNT_W   = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StApply  = 2'd1;
    localparam state_t StSample = 2'd2;
    localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle timer for the truth-table sweeper: loadable down-counter.
// expired flags the last settle cycle of the current vector.
module tt_settle_timer
    import tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [TT_CNT_W-1:0] load_val,
    input  logic                en,
    input  logic                clear,
    output logic                expired
);

    logic [TT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - TT_CNT_W'(1);
        end
    end

    assign expired = (cnt_q == TT_CNT_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps {A,B,C,D} through all 16 vectors and captures the evaluator result per vector.
// table is a reserved word, so the capture port is truth_table; TT_CHECK_EN adds expected/mismatch.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    input  logic                  out,
    output logic                  busy,
    output logic                  done,
`ifdef TT_CHECK_EN
    input  logic [TT_VECTORS-1:0] expected,
    output logic                  mismatch,
`endif
    output logic [TT_VECTORS-1:0] truth_table
);

    state_t                state_q, state_d;
    logic [TT_IDX_W-1:0]   idx_q, idx_d;
    logic [TT_VECTORS-1:0] table_q, table_d;
    logic                  tmr_load, tmr_en, tmr_clear, tmr_expired;
    logic                  accept, last_capture;

    tt_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TT_CNT_W'(SETTLE_CYCLES)),
        .en       (tmr_en),
        .clear    (tmr_clear),
        .expired  (tmr_expired)
    );

    assign accept       = (state_q == StIdle) && start;
    assign last_capture = (state_q == StSample) && !abort
                          && (idx_q == TT_IDX_W'(TT_VECTORS - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        table_d   = table_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_clear = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StApply;
                    idx_d    = '0;
                    table_d  = '0;
                    tmr_load = 1'b1;
                end
            end
            StApply: begin
                if (abort) begin
                    state_d   = StIdle;
                    idx_d     = '0;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        state_d = StSample;
                    end
                end
            end
            StSample: begin
                if (abort) begin
                    // Abort wins over capture; the partial table is kept as is.
                    state_d   = StIdle;
                    idx_d     = '0;
                    tmr_clear = 1'b1;
                end else begin
                    table_d[idx_q] = out;
                    if (idx_q == TT_IDX_W'(TT_VECTORS - 1)) begin
                        state_d = StDone;
                    end else begin
                        state_d  = StApply;
                        idx_d    = idx_q + TT_IDX_W'(1);
                        tmr_load = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
        end
    end

    assign busy         = (state_q == StApply) || (state_q == StSample);
    assign done         = (state_q == StDone);
    assign {A, B, C, D} = busy ? idx_q : '0;
    assign truth_table  = table_q;

`ifdef TT_CHECK_EN
    logic mismatch_q;

    // Compared against the post-capture table so the last vector is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else if (accept) begin
            mismatch_q <= 1'b0;
        end else if (last_capture) begin
            mismatch_q <= (table_d != expected);
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a behavioural evaluator (mode 0: A&B, mode 1: D).
// Define TT_CHECK_EN for both bench and RTL to exercise the expected/mismatch ports.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        A, B, C, D;
    logic        out;
    logic        busy;
    logic        done;
    logic [15:0] tbl;
    logic        mode;
`ifdef TT_CHECK_EN
    logic [15:0] expected;
    logic        mismatch;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_comb out = mode ? D : (A & B);

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D),
        .out         (out),
        .busy        (busy),
        .done        (done),
`ifdef TT_CHECK_EN
        .expected    (expected),
        .mismatch    (mismatch),
`endif
        .truth_table (tbl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
`ifdef TT_CHECK_EN
        expected = 16'h0000;
`endif
        #3;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_done got=%b want=00", {busy, done});
        end
        n_cmp++;
        if ({A, B, C, D} !== 4'h0) begin
            n_fail++; $display("FAIL reset_abcd got=%h want=0", {A, B, C, D});
        end
        n_cmp++;
        if (tbl !== 16'h0000) begin
            n_fail++; $display("FAIL reset_table got=%h want=0000", tbl);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        // abort alone in IDLE must do nothing
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_abort_busy got=%b want=0", busy);
        end
    endtask

    // out=A&B: busy for cycles 1..48, done on cycle 49, table F000.
    task automatic test_and_sweep();
        int bad_busy = 0;
        mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 48; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            tick();
        end
        n_cmp++;
        if (bad_busy != 0) begin
            n_fail++; $display("FAIL and_busy_window bad_cycles=%0d want=0", bad_busy);
        end
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_fail++; $display("FAIL and_done_c49 got=%b want=10", {done, busy});
        end
        n_cmp++;
        if (tbl !== 16'hF000) begin
            n_fail++; $display("FAIL and_table got=%h want=F000", tbl);
        end
        n_cmp++;
        if ({A, B, C, D} !== 4'h0) begin
            n_fail++; $display("FAIL and_abcd_done got=%h want=0", {A, B, C, D});
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL and_done_width got=%b want=0", done);
        end
        n_cmp++;
        if (tbl !== 16'hF000) begin
            n_fail++; $display("FAIL and_table_hold got=%h want=F000", tbl);
        end
    endtask

    // out=D: each vector held 3 cycles, stepping 0..15, table AAAA.
    task automatic test_d_stepping();
        int bad_vec = 0;
        mode = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int v = 0; v < 16; v++) begin
            for (int k = 0; k < 3; k++) begin
                if ({A, B, C, D} !== 4'(v)) bad_vec++;
                tick();
            end
        end
        n_cmp++;
        if (bad_vec != 0) begin
            n_fail++; $display("FAIL d_vector_steps bad_cycles=%0d want=0", bad_vec);
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL d_done_c49 got=%b want=1", done);
        end
        n_cmp++;
        if (tbl !== 16'hAAAA) begin
            n_fail++; $display("FAIL d_table got=%h want=AAAA", tbl);
        end
        tick();
    endtask

    task automatic test_abort();
        int done_seen = 0;
        // Abort in vector 5 APPLY (cycle 16) with out=A&B.
        mode = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        n_cmp++;
        if ({A, B, C, D} !== 4'h5) begin
            n_fail++; $display("FAIL abort_apply_vec got=%h want=5", {A, B, C, D});
        end
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++;
        if ({busy, done, A, B, C, D} !== 6'b0) begin
            n_fail++; $display("FAIL abort_apply_idle got=%b want=000000", {busy, done, A, B, C, D});
        end
        for (int c = 0; c < 5; c++) begin
            if (done === 1'b1) done_seen++;
            tick();
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL abort_no_done got=%0d want=0", done_seen);
        end
        n_cmp++;
        if (tbl !== 16'h0000) begin
            n_fail++; $display("FAIL abort_apply_table got=%h want=0000", tbl);
        end
        // Abort in vector 5 SAMPLE (cycle 18) with out=D: vector 5 must not be captured.
        mode = 1'b1;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL start_abort_idle got=%b want=1", busy);
        end
        for (int c = 1; c < 18; c++) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_sample_busy got=%b want=0", busy);
        end
        n_cmp++;
        if (tbl !== 16'h000A) begin
            n_fail++; $display("FAIL abort_sample_table got=%h want=000A", tbl);
        end
        tick();
    endtask

    task automatic test_async_reset();
        mode = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 28; c++) tick();
        n_cmp++;
        if ({A, B, C, D} !== 4'h9) begin
            n_fail++; $display("FAIL rst_pre_vec got=%h want=9", {A, B, C, D});
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, A, B, C, D} !== 6'b0 || tbl !== 16'h0000) begin
            n_fail++; $display("FAIL rst_async got=%b/%h want=000000/0000",
                               {busy, done, A, B, C, D}, tbl);
        end
        #1 rst = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if ({busy, A, B, C, D} !== 5'b10000) begin
            n_fail++; $display("FAIL rst_restart_v0 got=%b want=10000", {busy, A, B, C, D});
        end
        for (int c = 1; c < 48; c++) tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL rst_restart_c48 got=%b want=0", done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b1 || tbl !== 16'hAAAA) begin
            n_fail++; $display("FAIL rst_restart_done got=%b/%h want=1/AAAA", done, tbl);
        end
        tick();
    endtask

    // start held 120 cycles: done on cycles 49 and 99, IDLE on 50.
    task automatic test_back_to_back();
        int first = 0, second = 0, n_done = 0;
        logic busy50 = 1'bx, busy51 = 1'bx;
        logic [3:0] v25 = 4'hx;
        mode = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                if (first == 0) first = i; else if (second == 0) second = i;
            end
            if (i == 25) v25 = {A, B, C, D};
            if (i == 50) busy50 = busy;
            if (i == 51) busy51 = busy;
        end
        start = 1'b0;
        n_cmp++;
        if (first != 49 || second != 99 || n_done != 2) begin
            n_fail++; $display("FAIL b2b_done_cycles got=%0d,%0d,n=%0d want=49,99,n=2",
                               first, second, n_done);
        end
        n_cmp++;
        if (v25 !== 4'h8) begin
            n_fail++; $display("FAIL b2b_start_ignored got=%h want=8", v25);
        end
        n_cmp++;
        if ({busy50, busy51} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_idle_gap got=%b want=01", {busy50, busy51});
        end
        abort = 1'b1; tick(); abort = 1'b0;
        tick();
    endtask

`ifdef TT_CHECK_EN
    task automatic test_check();
        mode = 1'b0;
        expected = 16'hF000;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 49; c++) tick();
        n_cmp++;
        if ({done, mismatch} !== 2'b10) begin
            n_fail++; $display("FAIL chk_match got=%b want=10", {done, mismatch});
        end
        tick();
        expected = 16'hF001;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 49; c++) tick();
        n_cmp++;
        if ({done, mismatch} !== 2'b11) begin
            n_fail++; $display("FAIL chk_mismatch got=%b want=11", {done, mismatch});
        end
        for (int c = 0; c < 4; c++) tick();
        n_cmp++;
        if (mismatch !== 1'b1) begin
            n_fail++; $display("FAIL chk_hold got=%b want=1", mismatch);
        end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++;
        if (mismatch !== 1'b0) begin
            n_fail++; $display("FAIL chk_clear got=%b want=0", mismatch);
        end
        abort = 1'b1; tick(); abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_and_sweep();
        test_d_stepping();
        test_abort();
        test_async_reset();
        test_back_to_back();
`ifdef TT_CHECK_EN
        test_check();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
